// File: rtl/stream_demux_pkg.sv
// Shared types and constants for the 1-to-2 stream demultiplexer.
// Optional handshake counters are enabled by STREAM_DEMUX_COUNT_EN.
package stream_demux_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int CNT_WIDTH     = 16;

    localparam logic SEL_A = 1'b1;
    localparam logic SEL_B = 1'b0;

    typedef struct packed {
        logic                     valid;
        logic [DEFAULT_WIDTH-1:0] data;
    } slot_t;

    // A holding slot can take a new beat when it is empty or is being drained this cycle.
    function automatic logic slot_is_free(input logic valid, input logic ready);
        return !valid || ready;
    endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry output holding register with load/drain control and a free flag.
// With STREAM_DEMUX_COUNT_EN defined it also counts output handshakes (saturating).
module demux_slot
    import stream_demux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_load,
    input  logic [WIDTH-1:0]     i_data,
    input  logic                 i_ready,
    output logic                 o_valid,
    output logic [WIDTH-1:0]     o_data,
`ifdef STREAM_DEMUX_COUNT_EN
    output logic [CNT_WIDTH-1:0] o_cnt,
`endif
    output logic                 o_free
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic             w_drain;

    assign w_drain = r_valid && i_ready;
    assign o_free  = slot_is_free(r_valid, i_ready);
    assign o_valid = r_valid;
    assign o_data  = r_data;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering in simulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
        end else if (w_drain) begin
            r_valid <= 1'b0;
        end
    end

    // NOTE: the data register is reset too, because the outputs must read zero
    // while reset is asserted, not merely be marked invalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
        end else if (i_load) begin
            r_data <= i_data;
        end
    end

`ifdef STREAM_DEMUX_COUNT_EN
    logic [CNT_WIDTH-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_drain && (r_cnt != {CNT_WIDTH{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;
`endif

endmodule

// File: rtl/stream_demultiplexor.sv
// Registered 1-to-2 valid/ready demultiplexer; sel_a routes each accepted beat to A or B.
// Define STREAM_DEMUX_COUNT_EN to add saturating per-output handshake counters.
module stream_demultiplexor
    import stream_demux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sel_a,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 out_a_valid,
    input  logic                 out_a_ready,
    output logic [WIDTH-1:0]     out_a_data,
    output logic                 out_b_valid,
    input  logic                 out_b_ready,
`ifdef STREAM_DEMUX_COUNT_EN
    output logic [CNT_WIDTH-1:0] cnt_a,
    output logic [CNT_WIDTH-1:0] cnt_b,
`endif
    output logic [WIDTH-1:0]     out_b_data
);

    logic w_free_a;
    logic w_free_b;
    logic w_accept;
    logic w_load_a;
    logic w_load_b;

    // Readiness looks only at the selected slot, so a stalled consumer never blocks the other path.
    assign in_ready = (sel_a == SEL_A) ? w_free_a : w_free_b;
    assign w_accept = in_valid && in_ready;
    assign w_load_a = w_accept && (sel_a == SEL_A);
    assign w_load_b = w_accept && (sel_a == SEL_B);

    demux_slot #(
        .WIDTH   (WIDTH)
    ) u_slot_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_load_a),
        .i_data  (in_data),
        .i_ready (out_a_ready),
        .o_valid (out_a_valid),
        .o_data  (out_a_data),
`ifdef STREAM_DEMUX_COUNT_EN
        .o_cnt   (cnt_a),
`endif
        .o_free  (w_free_a)
    );

    demux_slot #(
        .WIDTH   (WIDTH)
    ) u_slot_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_load_b),
        .i_data  (in_data),
        .i_ready (out_b_ready),
        .o_valid (out_b_valid),
        .o_data  (out_b_data),
`ifdef STREAM_DEMUX_COUNT_EN
        .o_cnt   (cnt_b),
`endif
        .o_free  (w_free_b)
    );

endmodule
